rs_syndrome_checker: RTL

Receive-side companion to the RS(255,239) encoder. It consumes a serial 255-byte codeword, one byte per clock. It computes the 16 syndromes S_j = r(α^j), j = 1..16, over GF(256) with primitive polynomial 0x11D, which matches generator roots α^1..α^16. It reports the syndromes plus an error flag for the downstream Berlekamp-Massey / Chien stage, or for link-quality monitoring.

---
 rtl/rs_syndrome_checker_pkg.sv | 37 +++
 rtl/rs_syndrome_checker_gf_mult.sv | 18 +
 rtl/rs_syndrome_checker.sv | 101 ++++++++++
 3 files changed

// File: rtl/rs_syndrome_checker_pkg.sv
// Shared GF(256) constants and helpers for the RS(255,239) receive path.
// Pure declarations, no logic state.
// Not applicable (no handshake).
package rs_syndrome_checker_pkg;

  // Field definition: x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [8:0] GF_POLY  = 9'h11D;
  localparam int         CODE_LEN = 255;
  localparam int         MSG_LEN  = 239;
  localparam int         PAR_LEN  = 16;

  // alpha^1 .. alpha^16, the generator roots shared with the encoder
  localparam logic [7:0] ALPHA_POW [1:16] = '{
    8'd2,   8'd4,   8'd8,   8'd16,  8'd32,  8'd64,  8'd128, 8'd29,
    8'd58,  8'd116, 8'd232, 8'd205, 8'd135, 8'd19,  8'd38,  8'd76
  };

  // Accumulator control: idle, or accumulating a frame
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  // Shift-and-add GF(256) multiply; with a constant operand it folds to an XOR network
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_syndrome_checker_gf_mult.sv
// Multiply a GF(256) element by the constant A.
// Purely combinational, zero cycles.
// No flow control.
module gf256_const_mult
  import rs_syndrome_checker_pkg::*;
#(
  parameter logic [7:0] A = 8'h02
) (
  input  logic [7:0] i_a,
  output logic [7:0] o_p
);

  // constant multiply, reduced to XORs at elaboration
  always_comb begin
    o_p = gf_mul(i_a, A);
  end

endmodule

// File: rtl/rs_syndrome_checker.sv
// Serial RS(255,239) syndrome computation S_1..S_16 via Horner accumulation.
// syn_valid one cycle after the last byte (255 cycles after decode_start).
// No stall: one byte is consumed every cycle while busy.
module rs_syndrome_checker
  import rs_syndrome_checker_pkg::*;
#(
  parameter int CODE_LEN = 255,
  parameter int PAR_LEN  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   decode_start,
  input  logic [7:0]             code_in,
  output logic                   busy,
  output logic                   syn_valid,
  output logic [8*PAR_LEN-1:0]   syndrome,
  output logic                   err_flag
);

  localparam logic [7:0] LAST_IDX = 8'(CODE_LEN - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_byte_cnt;
  logic [7:0]            r_acc      [PAR_LEN];
  logic [7:0]            w_acc_mul  [PAR_LEN];
  logic [7:0]            w_acc_nxt  [PAR_LEN];
  logic [8*PAR_LEN-1:0]  w_syn_nxt;
  logic                  w_last;
  logic                  r_syn_valid;
  logic [8*PAR_LEN-1:0]  r_syndrome;
  logic                  r_err_flag;

  // One Horner step per syndrome: acc_j * alpha^j xor incoming byte
  for (genvar j = 0; j < PAR_LEN; j++) begin : g_acc
    gf256_const_mult #(.A(ALPHA_POW[j+1])) u_mul (
      .i_a (r_acc[j]),
      .o_p (w_acc_mul[j])
    );
    assign w_acc_nxt[j]        = w_acc_mul[j] ^ code_in;
    assign w_syn_nxt[8*j +: 8] = w_acc_nxt[j];
  end

  // The byte being presented now is the final one of the frame
  assign w_last = (r_state == S_ACC) && (r_byte_cnt == LAST_IDX);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state: a start always (re)opens a frame, even on the last byte of the previous one
  always_comb begin
    w_state_nxt = r_state;
    if (!en)               w_state_nxt = S_IDLE;
    else if (decode_start) w_state_nxt = S_ACC;
    else if (w_last)       w_state_nxt = S_IDLE;
  end

  // byte counter and accumulators; start loads code_in directly (Horner with old value dropped)
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_byte_cnt <= 8'd0;
      for (int j = 0; j < PAR_LEN; j++) r_acc[j] <= 8'h00;
    end else if (decode_start) begin
      r_byte_cnt <= 8'd1;
      for (int j = 0; j < PAR_LEN; j++) r_acc[j] <= code_in;
    end else if (r_state == S_ACC) begin
      if (w_last) begin
        r_byte_cnt <= 8'd0;
        for (int j = 0; j < PAR_LEN; j++) r_acc[j] <= 8'h00;
      end else begin
        r_byte_cnt <= r_byte_cnt + 8'd1;
        for (int j = 0; j < PAR_LEN; j++) r_acc[j] <= w_acc_nxt[j];
      end
    end
  end

  // capture the final accumulator values; syndrome/err_flag hold across en=0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_syn_valid <= 1'b0;
      r_syndrome  <= '0;
      r_err_flag  <= 1'b0;
    end else begin
      r_syn_valid <= en && w_last;
      if (en && w_last) begin
        r_syndrome <= w_syn_nxt;
        r_err_flag <= |w_syn_nxt;
      end
    end
  end

  assign busy      = (r_state == S_ACC);
  assign syn_valid = r_syn_valid;
  assign syndrome  = r_syndrome;
  assign err_flag  = r_err_flag;

endmodule
